joy_serial_poller: RTL



---
 rtl/joy_pkg.sv | 21 ++
 rtl/joy_serial_poller_if.sv | 20 ++
 rtl/joy_clk_div.sv | 49 ++++
 rtl/joy_serial_poller.sv | 131 +++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared state type, frame-length helper and idle level for the serial joystick poller.
package joy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LEAD,
    SHIFT,
    COMMIT
  } joy_state_e;

  localparam logic JOY_IDLE_LEVEL = 1'b1;

  // One load slot, the discarded lead slots, then the payload.
  function automatic int unsigned joy_frame_len(input int unsigned channels,
                                                input int unsigned bits_per_ch,
                                                input int unsigned lead_bits);
    return 1 + lead_bits + channels * bits_per_ch;
  endfunction

endpackage

// File: rtl/joy_serial_poller_if.sv
// Serial link to the external parallel-load / serial-out joystick chain.
interface joy_serial_poller_if;

  logic joy_clk;
  logic joy_load;
  logic joy_data;

  modport master (
    output joy_clk,
    output joy_load,
    input  joy_data
  );

  modport slave (
    input  joy_clk,
    input  joy_load,
    output joy_data
  );

endinterface

// File: rtl/joy_clk_div.sv
// Clock-enable divider: free-running JOY_CLK plus a one-cycle strobe on each rising toggle.
module joy_clk_div
  import joy_pkg::*;
#(
  parameter int unsigned DIV = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  joy_serial_poller_if.master  bus,
  output logic                 rise_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $fatal(1, "joy_clk_div: DIV must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    clk_d = clk_q;
    if (wrap) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  // The strobe is the cycle whose edge drives JOY_CLK from 0 to 1.
  assign rise_o      = wrap & ~clk_q;
  assign bus.joy_clk = clk_q;

endmodule

// File: rtl/joy_serial_poller.sv
// Polls the serial joystick chain once per frame and commits active-low button bits.
module joy_serial_poller
  import joy_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned BITS_PER_CH = 12,
  parameter int unsigned LEAD_BITS   = 1,
  parameter int unsigned DIV         = 16,
  parameter int unsigned DEBOUNCE    = 1
) (
  input  logic                            clk12,
  input  logic                            reset,
  input  logic                            poll_en,
  input  logic                            joy_data,
  output logic                            joy_clk,
  output logic                            joy_load,
  output logic [CHANNELS*BITS_PER_CH-1:0] joy_out,
  output logic                            frame_done
);

  localparam int unsigned TOTAL  = CHANNELS * BITS_PER_CH;
  localparam int unsigned FRAME  = joy_frame_len(CHANNELS, BITS_PER_CH, LEAD_BITS);
  localparam int unsigned SLOT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST     = SLOT_W'(FRAME - 1);
  localparam logic [SLOT_W-1:0] SLOT_LEAD_END = SLOT_W'(LEAD_BITS);

  if (DIV < 1 || BITS_PER_CH < 1 || CHANNELS < 1) begin : g_bad_params
    $fatal(1, "joy_serial_poller: DIV, BITS_PER_CH and CHANNELS must be at least 1");
  end

  joy_serial_poller_if bus ();

  logic rise;

  joy_clk_div #(
    .DIV (DIV)
  ) u_clk_div (
    .clk_i  (clk12),
    .rst_i  (reset),
    .bus    (bus),
    .rise_o (rise)
  );

  joy_state_e              state_q;
  logic [SLOT_W-1:0]       slot_q;
  logic                    load_q;
  logic [TOTAL-1:0]        raw_q, raw_d;
  logic [TOTAL-1:0]        prev_q;
  logic [TOTAL-1:0]        out_q;
  logic                    done_q;
  logic                    commit_ok;

  assign bus.joy_load = load_q;
  assign bus.joy_data = joy_data;
  assign joy_clk      = bus.joy_clk;
  assign joy_load     = bus.joy_load;
  assign joy_out      = out_q;
  assign frame_done   = done_q;

  // Payload bit k sits in slot 1+LEAD_BITS+k and lands in raw[TOTAL-1-k],
  // which simplifies to raw[i] being written in slot FRAME-1-i.
  always_comb begin
    raw_d = raw_q;
    for (int unsigned i = 0; i < TOTAL; i++) begin
      if (slot_q == SLOT_W'(FRAME - 1 - i)) begin
        raw_d[i] = bus.joy_data;
      end
    end
  end

  assign commit_ok = (DEBOUNCE == 0) || (raw_q == prev_q);

  always_ff @(posedge clk12) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      load_q  <= JOY_IDLE_LEVEL;
      raw_q   <= '1;
      prev_q  <= '1;
      out_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise && poll_en) begin
            state_q <= LOAD;
            load_q  <= ~JOY_IDLE_LEVEL;
            slot_q  <= '0;
          end
        end
        LOAD: begin
          if (rise) begin
            load_q  <= JOY_IDLE_LEVEL;
            slot_q  <= SLOT_W'(1);
            state_q <= (LEAD_BITS > 0) ? LEAD : SHIFT;
          end
        end
        LEAD: begin
          if (rise) begin
            slot_q <= slot_q + 1'b1;
            if (slot_q == SLOT_LEAD_END) begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (rise) begin
            raw_q <= raw_d;
            if (slot_q == SLOT_LAST) begin
              state_q <= COMMIT;
              slot_q  <= '0;
            end else begin
              slot_q <= slot_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          if (commit_ok) begin
            out_q  <= raw_q;
            done_q <= 1'b1;
          end
          prev_q  <= raw_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
